// File: rtl/fp16_accumulator.sv
// Streaming FP16 reduction stage: a registered accumulator around one combinational float_adder.
// Optional build macro ACC_RELU_EN clamps negative final sums (including -0) to +0 at the output register.

module float_adder (
    input  logic [15:0] num1,
    input  logic [15:0] num2,
    output logic [15:0] result
);
    // m[13] is the hidden bit at exponent e; m[2:0] are guard/round/sticky.
    function automatic logic [15:0] round_pack(input logic sgn, input logic [5:0] e_in,
                                               input logic [13:0] m);
        logic        up;
        logic [11:0] r;
        logic [5:0]  e;
        up = m[2] && (m[1] || m[0] || m[3]);
        r  = {1'b0, m[13:3]} + {11'd0, up};
        e  = e_in;
        if (r[11]) begin
            r = r >> 1;
            e = e + 6'd1;
        end
        if (e >= 6'd31)
            return {sgn, 5'h1f, 10'h000};
        if (!r[10])
            return {sgn, 5'h00, r[9:0]};
        return {sgn, e[4:0], r[9:0]};
    endfunction

    logic [15:0] a, b;
    logic [5:0]  ea_e, eb_e, d, e;
    logic [13:0] fa, fb, fb_sh, m;
    logic [14:0] sum;

    always_comb begin
        a = num1;
        b = num2;
        if (num2[14:0] > num1[14:0]) begin
            a = num2;
            b = num1;
        end
        ea_e  = (a[14:10] == 5'd0) ? 6'd1 : {1'b0, a[14:10]};
        eb_e  = (b[14:10] == 5'd0) ? 6'd1 : {1'b0, b[14:10]};
        fa    = {a[14:10] != 5'd0, a[9:0], 3'b000};
        fb    = {b[14:10] != 5'd0, b[9:0], 3'b000};
        d     = ea_e - eb_e;
        if (d >= 6'd14) begin
            fb_sh = {13'd0, |fb};
        end else begin
            fb_sh    = fb >> d;
            fb_sh[0] = fb_sh[0] | ((fb_sh << d) != fb);
        end
        if (a[15] == b[15])
            sum = {1'b0, fa} + {1'b0, fb_sh};
        else
            sum = {1'b0, fa} - {1'b0, fb_sh};

        e = ea_e;
        if (sum[14]) begin
            m = {sum[14:2], sum[1] | sum[0]};
            e = ea_e + 6'd1;
        end else begin
            m = sum[13:0];
            // Left-normalise, stopping at the subnormal exponent.
            for (int i = 0; i < 13; i++) begin
                if (!m[13] && e > 6'd1) begin
                    m = m << 1;
                    e = e - 6'd1;
                end
            end
        end

        result = round_pack(a[15], e, m);
        if (sum == 15'd0)
            result = {a[15] & b[15], 15'd0};
        // a holds the larger magnitude, so any NaN or Inf operand lands in a.
        if (a[14:10] == 5'h1f) begin
            if (a[9:0] != 10'd0 || (b[14:10] == 5'h1f && a[15] != b[15]))
                result = 16'h7e00;
            else
                result = a;
        end
    end
endmodule

module fp16_accumulator #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t           state, state_nxt;
    logic [15:0]      acc, acc_nxt, sum, out_data_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc, out_count_nxt;
    logic             ovf, ovf_nxt, out_ovf_nxt, accept, wrap;

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef ACC_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    float_adder u_add (
        .num1   (acc),
        .num2   (in_data),
        .result (sum)
    );

    assign out_valid = (state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign wrap      = (cnt_inc == '0);

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        ovf_nxt       = ovf;
        out_data_nxt  = out_data;
        out_count_nxt = out_count;
        out_ovf_nxt   = out_ovf;
        case (state)
            IDLE, HOLD: begin
                if (state == HOLD && out_ready)
                    state_nxt = IDLE;
                // A new vector's first term bypasses the adder.
                if (accept) begin
                    if (!in_last) begin
                        acc_nxt   = in_data;
                        cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
                        ovf_nxt   = 1'b0;
                        state_nxt = ACCUM;
                    end else begin
                        out_data_nxt  = relu(in_data);
                        out_count_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                        out_ovf_nxt   = 1'b0;
                        state_nxt     = HOLD;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (!in_last) begin
                        acc_nxt = sum;
                        cnt_nxt = cnt_inc;
                        ovf_nxt = ovf | wrap;
                    end else begin
                        out_data_nxt  = relu(sum);
                        out_count_nxt = cnt_inc;
                        out_ovf_nxt   = ovf | wrap;
                        acc_nxt       = 16'h0000;
                        cnt_nxt       = '0;
                        ovf_nxt       = 1'b0;
                        state_nxt     = HOLD;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered accumulator and output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_data  <= 16'h0000;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            out_data  <= out_data_nxt;
            out_count <= out_count_nxt;
            out_ovf   <= out_ovf_nxt;
        end
    end
endmodule

// File: tb/tb_fp16_accumulator.sv
// Directed bench for fp16_accumulator: vector table plus hand-written handshake/reset sequences.
// Built with a narrow counter (CNT_W=3) so the wrap flag is reachable in a few cycles.

module tb_fp16_accumulator;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_last;
    logic [15:0]   in_data;
    logic          out_valid, out_ready, out_ovf;
    logic [15:0]   out_data;
    logic [CW-1:0] out_count;

    int total  = 0;
    int passed = 0;

    fp16_accumulator #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        int              n;
        logic [3:0][15:0] t;
        logic [15:0]     exp_d;
        logic [CW-1:0]   exp_c;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Present a term at a negedge, wait (bounded) for in_ready, return at the negedge after acceptance.
    task automatic drive(input logic [15:0] d, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        #1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t == 20) chk("drive_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    vec_t vecs[8];
    logic [15:0] neg_sum;

    initial begin
`ifdef ACC_RELU_EN
        neg_sum = 16'h0000;
`else
        neg_sum = 16'hc000;
`endif
        vecs[0] = '{"three_ones",  3, {16'h0000, 16'h3c00, 16'h3c00, 16'h3c00}, 16'h4200, 3'd3};
        vecs[1] = '{"single_two",  1, {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 16'h4000, 3'd1};
        vecs[2] = '{"neg_ones",    2, {16'h0000, 16'h0000, 16'hbc00, 16'hbc00}, neg_sum,  3'd2};
        vecs[3] = '{"cancel",      2, {16'h0000, 16'h0000, 16'hbc00, 16'h3c00}, 16'h0000, 3'd2};
        vecs[4] = '{"fractions",   4, {16'h3c00, 16'h3000, 16'h3400, 16'h3800}, 16'h3f80, 3'd4};
        vecs[5] = '{"overflow",    2, {16'h0000, 16'h0000, 16'h7bff, 16'h7bff}, 16'h7c00, 3'd2};
        vecs[6] = '{"subnormal",   2, {16'h0000, 16'h0000, 16'h0001, 16'h0001}, 16'h0002, 3'd2};
        vecs[7] = '{"round_even",  3, {16'h0000, 16'h1000, 16'h1400, 16'h3c00}, 16'h3c02, 3'd3};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {16'd0, out_data},  32'd0);
        chk("rst_count", {29'd0, out_count}, 32'd0);
        chk("rst_ovf",   {31'd0, out_ovf},   32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                drive(vecs[i].t[k], k == vecs[i].n - 1);
                if (k < vecs[i].n - 1)
                    chk({vecs[i].name, "_early"}, {31'd0, out_valid}, 32'd0);
            end
            in_valid = 1'b0;
            chk({vecs[i].name, "_valid"}, {31'd0, out_valid}, 32'd1);
            chk({vecs[i].name, "_data"},  {16'd0, out_data},  {16'd0, vecs[i].exp_d});
            chk({vecs[i].name, "_count"}, {29'd0, out_count}, {29'd0, vecs[i].exp_c});
            chk({vecs[i].name, "_ovf"},   {31'd0, out_ovf},   32'd0);
            @(negedge clk);
            chk({vecs[i].name, "_drain"}, {31'd0, out_valid}, 32'd0);
        end

        // Backpressure with a gap inside the vector; a pending term waits out the stall.
        out_ready = 1'b0;
        drive(16'h4000, 1'b0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        drive(16'h4000, 1'b1);
        in_valid = 1'b1; in_data = 16'h3c00; in_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data",  {16'd0, out_data},  32'h4400);
            chk("bp_ready", {31'd0, in_ready},  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_data",  {16'd0, out_data},  32'h3c00);
        chk("bp_next_count", {29'd0, out_count}, 32'd1);
        @(negedge clk);

        // Back-to-back vectors, no input stall.
        drive(16'h3e00, 1'b0);
        drive(16'h3e00, 1'b1);
        chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
        chk("b2b_data1",  {16'd0, out_data},  32'h4200);
        chk("b2b_count1", {29'd0, out_count}, 32'd2);
        in_valid = 1'b1; in_data = 16'h4e00; in_last = 1'b0;
        #1;
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("b2b_gap", {31'd0, out_valid}, 32'd0);
        drive(16'h4e00, 1'b1);
        in_valid = 1'b0;
        chk("b2b_valid2", {31'd0, out_valid}, 32'd1);
        chk("b2b_data2",  {16'd0, out_data},  32'h5200);
        @(negedge clk);

        // Counter wrap: eight terms with a 3-bit counter.
        for (int k = 0; k < 8; k++) drive(16'h3c00, k == 7);
        in_valid = 1'b0;
        chk("wrap_data",  {16'd0, out_data},  32'h4800);
        chk("wrap_count", {29'd0, out_count}, 32'd0);
        chk("wrap_ovf",   {31'd0, out_ovf},   32'd1);
        @(negedge clk);
        drive(16'h3c00, 1'b1);
        in_valid = 1'b0;
        chk("wrap_clear", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);

        // Reset mid-vector discards the partial sum and clears the output registers.
        drive(16'h4000, 1'b1);
        drive(16'h3c00, 1'b0);
        drive(16'h3c00, 1'b0);
        in_valid = 1'b0;
        chk("pre_rst_data", {16'd0, out_data}, 32'h4000);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_data",  {16'd0, out_data},  32'd0);
        chk("midrst_count", {29'd0, out_count}, 32'd0);
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(16'h3c00, 1'b1);
        in_valid = 1'b0;
        chk("post_rst_data",  {16'd0, out_data},  32'h3c00);
        chk("post_rst_count", {29'd0, out_count}, 32'd1);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
